// File: rtl/irrigation_timer_pkg.sv
// -----------------------------------------------------------------------------
// irrigation_timer_pkg
// Shared types and constants for the irrigation countdown timer.
//   - timer_state_e : controller states (IDLE, LOAD, RUN, DONE)
//   - digit widths / maximum values for the mm:ss BCD fields
//   - bcd_time_t    : packed mm:ss digit bundle
//   - preset_to_bcd : converts a whole-minute preset into an mm:00 bundle
// -----------------------------------------------------------------------------
package irrigation_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } timer_state_e;

  localparam int MIN_D_W = 2;
  localparam int MIN_U_W = 4;
  localparam int SEC_D_W = 3;
  localparam int SEC_U_W = 4;

  localparam int SEC_U_MAX = 9;
  localparam int SEC_D_MAX = 5;
  localparam int MIN_U_MAX = 9;
  localparam int MIN_D_MAX = 3;

  // Largest preset representable with a minutes-tens digit of 0..3.
  localparam int MAX_PRESET_MIN = 39;

  typedef struct packed {
    logic [MIN_D_W-1:0] min_d;
    logic [MIN_U_W-1:0] min_u;
    logic [SEC_D_W-1:0] sec_d;
    logic [SEC_U_W-1:0] sec_u;
  } bcd_time_t;

  function automatic bcd_time_t preset_to_bcd(input int minutes);
    bcd_time_t t;
    t.min_d = MIN_D_W'(minutes / 10);
    t.min_u = MIN_U_W'(minutes % 10);
    t.sec_d = '0;
    t.sec_u = '0;
    return t;
  endfunction

endpackage

// File: rtl/irrigation_countdown_timer_bcd_down_digit.sv
// -----------------------------------------------------------------------------
// bcd_down_digit
// One decimal digit of a down-counter with a parameterised maximum value.
// Digits are chained through borrow_in/borrow_out; the least significant digit
// has borrow_in tied high so that dec_en alone decrements it.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (digit -> 0)
//   load         : load load_val (wins over decrement)
//   load_val     : value to load
//   dec_en       : decrement strobe for the whole chain
//   borrow_in    : borrow request from the next less significant digit
//   digit        : registered digit value (0..MAX)
//   borrow_out   : this digit is 0 and a borrow reached it (passes upward)
// -----------------------------------------------------------------------------
module bcd_down_digit #(
  parameter int W   = 4,
  parameter int MAX = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec_en,
  input  logic         borrow_in,
  output logic [W-1:0] digit,
  output logic         borrow_out
);
  import irrigation_timer_pkg::*;

  logic [W-1:0] digit_q;
  logic [W-1:0] digit_d;
  logic         at_zero_s;

  assign at_zero_s  = (digit_q == '0);
  assign borrow_out = borrow_in & at_zero_s;
  assign digit      = digit_q;

  // Next digit value: load, borrow-driven decrement with wrap to MAX, or hold.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (dec_en && borrow_in) begin
      if (at_zero_s) begin
        digit_d = W'(MAX);
      end else begin
        digit_d = digit_q - W'(1);
      end
    end else begin
      digit_d = digit_q;
    end
  end

  // Digit register.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/irrigation_countdown_timer.sv
// -----------------------------------------------------------------------------
// irrigation_countdown_timer
// BCD mm:ss countdown timer. While reload is high it holds the mode-dependent
// preset; after reload falls it counts down once per CLK_HZ cycles (pause
// freezes both the prescaler and the digits) and pulses expired on reaching
// 00:00, where it stays until the next reload or reset.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   reload            : level, hold timer at preset while high
//   splinker_mode_on  : 1 = sprinkler preset, 0 = drip preset
//   pause             : level, freeze countdown and prescaler
//   minutes_d/_u      : minutes tens (0..3) / units (0..9)
//   seconds_d/_u      : seconds tens (0..5) / units (0..9)
//   running           : high while in RUN
//   expired           : one-cycle pulse on entry to DONE
// -----------------------------------------------------------------------------
module irrigation_countdown_timer
  import irrigation_timer_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int SPRINKLER_MIN = 10,
  parameter int DRIP_MIN      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reload,
  input  logic       splinker_mode_on,
  input  logic       pause,
  output logic [1:0] minutes_d,
  output logic [3:0] minutes_u,
  output logic [2:0] seconds_d,
  output logic [3:0] seconds_u,
  output logic       running,
  output logic       expired
);

  if (CLK_HZ < 2) begin : g_bad_clk_hz
    $error("irrigation_countdown_timer: CLK_HZ must be at least 2");
  end
  if (SPRINKLER_MIN < 0 || SPRINKLER_MIN > MAX_PRESET_MIN) begin : g_bad_sprinkler
    $error("irrigation_countdown_timer: SPRINKLER_MIN must be 0..39");
  end
  if (DRIP_MIN < 0 || DRIP_MIN > MAX_PRESET_MIN) begin : g_bad_drip
    $error("irrigation_countdown_timer: DRIP_MIN must be 0..39");
  end

  localparam int                  PRESC_W     = $clog2(CLK_HZ);
  localparam logic [PRESC_W-1:0]  TICK_MAX    = PRESC_W'(CLK_HZ - 1);
  localparam bcd_time_t           SPR_PRESET  = preset_to_bcd(SPRINKLER_MIN);
  localparam bcd_time_t           DRIP_PRESET = preset_to_bcd(DRIP_MIN);

  timer_state_e       state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               running_q, running_d;
  logic               expired_q, expired_d;

  logic               load_s;
  logic               dec_s;
  bcd_time_t          load_val_s;

  logic [MIN_D_W-1:0] min_d_s;
  logic [MIN_U_W-1:0] min_u_s;
  logic [SEC_D_W-1:0] sec_d_s;
  logic [SEC_U_W-1:0] sec_u_s;
  logic               sec_u_borrow_s;
  logic               sec_d_borrow_s;
  logic               min_u_borrow_s;
  logic               min_d_borrow_s;
  logic               time_zero_s;
  logic               time_one_s;

  assign load_val_s = splinker_mode_on ? SPR_PRESET : DRIP_PRESET;

  // With the chain's borrow_in tied high, the top borrow_out is set exactly
  // when every digit is zero, so it doubles as the 00:00 detector.
  assign time_zero_s = min_d_borrow_s;
  assign time_one_s  = (min_d_s == '0) && (min_u_s == '0) &&
                       (sec_d_s == '0) && (sec_u_s == SEC_U_W'(1));

  bcd_down_digit #(.W(SEC_U_W), .MAX(SEC_U_MAX)) u_sec_u (
    .clk        (clk),
    .reset      (reset),
    .load       (load_s),
    .load_val   (load_val_s.sec_u),
    .dec_en     (dec_s),
    .borrow_in  (1'b1),
    .digit      (sec_u_s),
    .borrow_out (sec_u_borrow_s)
  );

  bcd_down_digit #(.W(SEC_D_W), .MAX(SEC_D_MAX)) u_sec_d (
    .clk        (clk),
    .reset      (reset),
    .load       (load_s),
    .load_val   (load_val_s.sec_d),
    .dec_en     (dec_s),
    .borrow_in  (sec_u_borrow_s),
    .digit      (sec_d_s),
    .borrow_out (sec_d_borrow_s)
  );

  bcd_down_digit #(.W(MIN_U_W), .MAX(MIN_U_MAX)) u_min_u (
    .clk        (clk),
    .reset      (reset),
    .load       (load_s),
    .load_val   (load_val_s.min_u),
    .dec_en     (dec_s),
    .borrow_in  (sec_d_borrow_s),
    .digit      (min_u_s),
    .borrow_out (min_u_borrow_s)
  );

  bcd_down_digit #(.W(MIN_D_W), .MAX(MIN_D_MAX)) u_min_d (
    .clk        (clk),
    .reset      (reset),
    .load       (load_s),
    .load_val   (load_val_s.min_d),
    .dec_en     (dec_s),
    .borrow_in  (min_u_borrow_s),
    .digit      (min_d_s),
    .borrow_out (min_d_borrow_s)
  );

  // Next-state, prescaler and digit-control logic; reload overrides everything
  // except reset, pause overrides the tick.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    expired_d = 1'b0;
    load_s    = 1'b0;
    dec_s     = 1'b0;
    if (reload) begin
      state_d = ST_LOAD;
      presc_d = '0;
      load_s  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_LOAD: begin
          state_d = ST_RUN;
          presc_d = '0;
        end
        ST_RUN: begin
          if (pause) begin
            presc_d = presc_q;
          end else if (presc_q == TICK_MAX) begin
            presc_d = '0;
            // Never decrement below 00:00; a zero preset just finishes.
            dec_s   = ~time_zero_s;
            if (time_zero_s || time_one_s) begin
              state_d   = ST_DONE;
              expired_d = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
          presc_d = '0;
        end
      endcase
    end
    running_d = (state_d == ST_RUN);
  end

  // Controller registers, including the registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end

  assign minutes_d = min_d_s;
  assign minutes_u = min_u_s;
  assign seconds_d = sec_d_s;
  assign seconds_u = sec_u_s;
  assign running   = running_q;
  assign expired   = expired_q;

endmodule
